// File: rtl/tester_trace_driver.sv
// tester_trace_driver: self-checking write/read-back stimulus driver for the tester tile trace port.
//
// For each of NUM_REQS transactions it issues a write-memory request, streams a
// deterministic payload (byte k of transaction i = (i + k) mod 256, byte 0 in the
// MSBs, pad bytes driven 0), issues a read-memory request at the same address and
// checks the returned beats against the regenerated payload (pad bytes ignored).
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start                            one-cycle pulse, starts a run from IDLE
//   done, pass                       run finished (sticky) / all checks passed
//   fail_req_idx, fail_flit_idx      transaction and flit of the first failure
//   trace_tester_tile_wr_mem_req_*   write request out   (rdy: tester_tile_trace_wr_mem_req_rdy)
//   trace_tester_tile_data*          write payload out   (rdy: tester_tile_trace_data_rdy)
//   trace_tester_tile_rd_mem_req_*   read request out    (rdy: tester_tile_trace_rd_mem_req_rdy)
//   tester_tile_trace_data*          read return in      (rdy: trace_tester_tile_data_rdy)
//
// Optional feature macro: TESTER_TRACE_DRIVER_TIMEOUT_EN adds a per-state watchdog
// of TIMEOUT_CYCLES that fails the run with fail_flit_idx = 16'hFFFF.

`ifndef TRACE_ADDR_W
`define TRACE_ADDR_W 32
`endif
`ifndef TRACE_SIZE_W
`define TRACE_SIZE_W 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module tester_trace_driver #(
   parameter int NUM_REQS       = 4,
   parameter int BASE_ADDR      = 0,
   parameter int ADDR_STRIDE    = 'h100,
   parameter int MIN_SIZE       = 40,
   parameter int SIZE_STEP      = 24,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         done,
   output logic                         pass,
   output logic [15:0]                  fail_req_idx,
   output logic [15:0]                  fail_flit_idx,
   output logic                         trace_tester_tile_wr_mem_req_val,
   output logic [`TRACE_ADDR_W-1:0]     trace_tester_tile_wr_mem_req_addr,
   output logic [`TRACE_SIZE_W-1:0]     trace_tester_tile_wr_mem_req_size,
   input  logic                         tester_tile_trace_wr_mem_req_rdy,
   output logic                         trace_tester_tile_data_val,
   output logic [`MAC_INTERFACE_W-1:0]  trace_tester_tile_data,
   output logic                         trace_tester_tile_data_last,
   output logic [`MAC_PADBYTES_W-1:0]   trace_tester_tile_data_padbytes,
   input  logic                         tester_tile_trace_data_rdy,
   output logic                         trace_tester_tile_rd_mem_req_val,
   output logic [`TRACE_ADDR_W-1:0]     trace_tester_tile_rd_mem_req_addr,
   output logic [`TRACE_SIZE_W-1:0]     trace_tester_tile_rd_mem_req_size,
   input  logic                         tester_tile_trace_rd_mem_req_rdy,
   input  logic                         tester_tile_trace_data_val,
   input  logic [`MAC_INTERFACE_W-1:0]  tester_tile_trace_data,
   input  logic                         tester_tile_trace_data_last,
   input  logic [`MAC_PADBYTES_W-1:0]   tester_tile_trace_data_padbytes,
   output logic                         trace_tester_tile_data_rdy
);
   localparam int DW = `MAC_INTERFACE_W;
   localparam int BB = DW / 8;
   localparam int LB = $clog2(BB);
   localparam int AW = `TRACE_ADDR_W;
   localparam int SW = `TRACE_SIZE_W;
   localparam int PW = `MAC_PADBYTES_W;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_DATA, RD_REQ, RD_CHECK, PASS, FAIL} state_t;

   state_t        state_q, state_d;
   logic [15:0]   idx_q, idx_d;
   logic [15:0]   flit_q, flit_d;
   logic [15:0]   size_q, size_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic [15:0]   fail_req_q, fail_req_d;
   logic [15:0]   fail_flit_q, fail_flit_d;
   logic [15:0]   nflits;
   logic          last_flit;
   logic [PW-1:0] pad_last;
   logic [DW-1:0] exp_data;
   logic [BB-1:0] byte_ok;
   logic          data_bad;
   logic          beat_bad;

   // addr/size of the current transaction are kept as running accumulators
   // so no multiplier is needed for i*ADDR_STRIDE or i*SIZE_STEP.
   assign nflits    = 16'((17'(size_q) + 17'(BB - 1)) >> LB);
   assign last_flit = flit_q == nflits - 16'd1;
   // Pad count of the last beat is (-size) mod B.
   assign pad_last  = PW'(LB'(16'd0 - size_q));

   // Expected flit for (idx_q, flit_q); shared by the write stream and the read check.
   always_comb begin
      exp_data = '0;
      byte_ok  = '0;
      data_bad = 1'b0;
      for (int b = 0; b < BB; b++) begin
         byte_ok[b] = 32'(flit_q) * BB + b < 32'(size_q);
         exp_data[DW-1-8*b -: 8] = byte_ok[b] ? 8'(32'(idx_q) + 32'(flit_q) * BB + b) : 8'h00;
         data_bad = data_bad | (byte_ok[b] & (tester_tile_trace_data[DW-1-8*b -: 8] != exp_data[DW-1-8*b -: 8]));
      end
   end

   assign beat_bad = data_bad | (tester_tile_trace_data_last != last_flit) |
                     (last_flit & (tester_tile_trace_data_padbytes != pad_last));

`ifdef TESTER_TRACE_DRIVER_TIMEOUT_EN
   logic [31:0] tmr_q, tmr_d;
   logic        xfer;
   logic        active;
   assign active = state_q inside {WR_REQ, WR_DATA, RD_REQ, RD_CHECK};
   // Any accepted beat (and therefore any state change) restarts the watchdog.
   assign xfer = (state_q == WR_REQ   && tester_tile_trace_wr_mem_req_rdy) ||
                 (state_q == WR_DATA  && tester_tile_trace_data_rdy) ||
                 (state_q == RD_REQ   && tester_tile_trace_rd_mem_req_rdy) ||
                 (state_q == RD_CHECK && tester_tile_trace_data_val);
   assign tmr_d = (!active || xfer) ? 32'd0 : tmr_q + 32'd1;
   always_ff @(posedge clk) begin
      if (rst) tmr_q <= '0;
      else     tmr_q <= tmr_d;
   end
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      flit_d      = flit_q;
      size_d      = size_q;
      addr_d      = addr_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_req_d  = fail_req_q;
      fail_flit_d = fail_flit_q;
      case (state_q)
         IDLE: if (start) begin
            state_d     = WR_REQ;
            idx_d       = '0;
            flit_d      = '0;
            addr_d      = AW'(BASE_ADDR);
            size_d      = 16'(MIN_SIZE);
            done_d      = 1'b0;
            pass_d      = 1'b0;
            fail_req_d  = '0;
            fail_flit_d = '0;
         end
         WR_REQ: if (tester_tile_trace_wr_mem_req_rdy) begin
            state_d = WR_DATA;
            flit_d  = '0;
         end
         WR_DATA: if (tester_tile_trace_data_rdy) begin
            flit_d  = last_flit ? 16'd0 : flit_q + 16'd1;
            state_d = last_flit ? RD_REQ : WR_DATA;
         end
         RD_REQ: if (tester_tile_trace_rd_mem_req_rdy) begin
            state_d = RD_CHECK;
            flit_d  = '0;
         end
         RD_CHECK: if (tester_tile_trace_data_val) begin
            if (beat_bad) begin
               state_d     = FAIL;
               done_d      = 1'b1;
               pass_d      = 1'b0;
               fail_req_d  = idx_q;
               fail_flit_d = flit_q;
            end else if (!last_flit) begin
               flit_d = flit_q + 16'd1;
            end else if (idx_q == 16'(NUM_REQS - 1)) begin
               state_d = PASS;
               done_d  = 1'b1;
               pass_d  = 1'b1;
            end else begin
               state_d = WR_REQ;
               idx_d   = idx_q + 16'd1;
               addr_d  = addr_q + AW'(ADDR_STRIDE);
               size_d  = size_q + 16'(SIZE_STEP);
               flit_d  = '0;
            end
         end
         PASS:    state_d = IDLE;
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef TESTER_TRACE_DRIVER_TIMEOUT_EN
      if (active && !xfer && tmr_q == 32'(TIMEOUT_CYCLES - 1)) begin
         state_d     = FAIL;
         done_d      = 1'b1;
         pass_d      = 1'b0;
         fail_req_d  = idx_q;
         fail_flit_d = 16'hFFFF;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         flit_q      <= '0;
         size_q      <= '0;
         addr_q      <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_req_q  <= '0;
         fail_flit_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         flit_q      <= flit_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_req_q  <= fail_req_d;
         fail_flit_q <= fail_flit_d;
      end
   end

   // All handshake outputs decode registered state, so fields stay stable until rdy.
   assign done                              = done_q;
   assign pass                              = pass_q;
   assign fail_req_idx                      = fail_req_q;
   assign fail_flit_idx                     = fail_flit_q;
   assign trace_tester_tile_wr_mem_req_val  = state_q == WR_REQ;
   assign trace_tester_tile_wr_mem_req_addr = addr_q;
   assign trace_tester_tile_wr_mem_req_size = SW'(size_q);
   assign trace_tester_tile_data_val        = state_q == WR_DATA;
   assign trace_tester_tile_data            = exp_data;
   assign trace_tester_tile_data_last       = trace_tester_tile_data_val & last_flit;
   assign trace_tester_tile_data_padbytes   = trace_tester_tile_data_last ? pad_last : '0;
   assign trace_tester_tile_rd_mem_req_val  = state_q == RD_REQ;
   assign trace_tester_tile_rd_mem_req_addr = addr_q;
   assign trace_tester_tile_rd_mem_req_size = SW'(size_q);
   assign trace_tester_tile_data_rdy        = state_q == RD_CHECK;

endmodule

// File: tb/tb_tester_trace_driver.sv
// tb_tester_trace_driver: randomized tile model and reference checker for tester_trace_driver.

`ifndef TRACE_ADDR_W
`define TRACE_ADDR_W 32
`endif
`ifndef TRACE_SIZE_W
`define TRACE_SIZE_W 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module tb_tester_trace_driver;
   localparam int DW = `MAC_INTERFACE_W;
   localparam int BB = DW / 8;
   localparam int AW = `TRACE_ADDR_W;
   localparam int SW = `TRACE_SIZE_W;
   localparam int PW = `MAC_PADBYTES_W;

   logic          clk = 1'b0;
   logic          rst, start;
   logic          done, pass;
   logic [15:0]   fail_req_idx, fail_flit_idx;
   logic          wr_val, wr_rdy;
   logic [AW-1:0] wr_addr;
   logic [SW-1:0] wr_size;
   logic          d_val, d_last, d_rdy;
   logic [DW-1:0] d_data;
   logic [PW-1:0] d_pad;
   logic          rd_val, rd_rdy;
   logic [AW-1:0] rd_addr;
   logic [SW-1:0] rd_size;
   logic          r_val, r_last, r_rdy;
   logic [DW-1:0] r_data;
   logic [PW-1:0] r_pad;

   always #5 clk = ~clk;

   tester_trace_driver dut (
      .clk                               (clk),
      .rst                               (rst),
      .start                             (start),
      .done                              (done),
      .pass                              (pass),
      .fail_req_idx                      (fail_req_idx),
      .fail_flit_idx                     (fail_flit_idx),
      .trace_tester_tile_wr_mem_req_val  (wr_val),
      .trace_tester_tile_wr_mem_req_addr (wr_addr),
      .trace_tester_tile_wr_mem_req_size (wr_size),
      .tester_tile_trace_wr_mem_req_rdy  (wr_rdy),
      .trace_tester_tile_data_val        (d_val),
      .trace_tester_tile_data            (d_data),
      .trace_tester_tile_data_last       (d_last),
      .trace_tester_tile_data_padbytes   (d_pad),
      .tester_tile_trace_data_rdy        (d_rdy),
      .trace_tester_tile_rd_mem_req_val  (rd_val),
      .trace_tester_tile_rd_mem_req_addr (rd_addr),
      .trace_tester_tile_rd_mem_req_size (rd_size),
      .tester_tile_trace_rd_mem_req_rdy  (rd_rdy),
      .tester_tile_trace_data_val        (r_val),
      .tester_tile_trace_data            (r_data),
      .tester_tile_trace_data_last       (r_last),
      .tester_tile_trace_data_padbytes   (r_pad),
      .trace_tester_tile_data_rdy        (r_rdy)
   );

   int vectors = 0;
   int miscompares = 0;
   byte unsigned mem [int];
   int q_txn[$], q_size[$];
   int wr_cnt, rd_cnt, cur_i, wbeat, ret_j, flt;
   bit rnd, hold_rd;
   logic          p_wv, p_wr, p_dv, p_dr, p_rv, p_rr, p_dl;
   logic [AW-1:0] p_wa, p_ra;
   logic [SW-1:0] p_ws, p_rs;
   logic [DW-1:0] p_dd;
   logic [PW-1:0] p_dp;

   function automatic int exp_size(int i);
      return 40 + 24 * i;
   endfunction
   function automatic int nfl(int s);
      return (s + BB - 1) / BB;
   endfunction
   function automatic int pad_of(int s);
      return nfl(s) * BB - s;
   endfunction
   function automatic logic [DW-1:0] payload(int i, int j, int s);
      logic [DW-1:0] v;
      v = '0;
      for (int b = 0; b < BB; b++)
         if (j * BB + b < s) v[DW-1-8*b -: 8] = 8'((i + j * BB + b) % 256);
      return v;
   endfunction
   function bit coin();
      return rnd ? ($urandom_range(3) != 0) : 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of the tile model: check held fields, pick rdys, account transfers.
   task automatic step();
      logic [DW-1:0] rv;
      byte unsigned  v;
      int            sz, nf, k;
      @(negedge clk);
      if (p_wv && !p_wr) begin
         chk("wr_hold_val", 64'(wr_val), 64'(1));
         chk("wr_hold_addr", 64'(wr_addr), 64'(p_wa));
         chk("wr_hold_size", 64'(wr_size), 64'(p_ws));
      end
      if (p_dv && !p_dr) begin
         chk("data_hold_val", 64'(d_val), 64'(1));
         chkw("data_hold", d_data, p_dd);
         chk("data_hold_last", 64'(d_last), 64'(p_dl));
         chk("data_hold_pad", 64'(d_pad), 64'(p_dp));
      end
      if (p_rv && !p_rr) begin
         chk("rd_hold_val", 64'(rd_val), 64'(1));
         chk("rd_hold_addr", 64'(rd_addr), 64'(p_ra));
         chk("rd_hold_size", 64'(rd_size), 64'(p_rs));
      end
      wr_rdy = coin();
      d_rdy  = coin();
      rd_rdy = hold_rd ? 1'b0 : coin();
      r_val  = 1'b0;
      if (q_txn.size() > 0 && coin()) begin
         sz = q_size[0];
         nf = nfl(sz);
         rv = '0;
         for (int b = 0; b < BB; b++) begin
            k = ret_j * BB + b;
            v = 8'hFF;
            if (k < sz) v = mem.exists(q_txn[0] * 256 + k) ? mem[q_txn[0] * 256 + k] : 8'h00;
            if (flt == 1 && q_txn[0] == 2 && ret_j == 1 && b == 5) v = ~v;
            rv[DW-1-8*b -: 8] = v;
         end
         r_val  = 1'b1;
         r_data = rv;
         r_last = (ret_j == nf - 1) || (flt == 2 && q_txn[0] == 0 && ret_j == 0);
         r_pad  = (ret_j == nf - 1) ? PW'(pad_of(sz)) : '0;
         if (r_rdy) begin
            if (r_last) begin
               void'(q_txn.pop_front());
               void'(q_size.pop_front());
               ret_j = 0;
            end else ret_j++;
         end
      end
      if (d_val && d_rdy) begin
         sz = exp_size(cur_i);
         nf = nfl(sz);
         chkw("wr_data", d_data, payload(cur_i, wbeat, sz));
         chk("wr_last", 64'(d_last), 64'(wbeat == nf - 1));
         chk("wr_pad", 64'(d_pad), 64'((wbeat == nf - 1) ? pad_of(sz) : 0));
         for (int b = 0; b < BB; b++)
            if (wbeat * BB + b < sz) mem[cur_i * 256 + wbeat * BB + b] = d_data[DW-1-8*b -: 8];
         wbeat++;
      end
      if (wr_val && wr_rdy) begin
         chk("wr_addr", 64'(wr_addr), 64'(wr_cnt * 256));
         chk("wr_size", 64'(wr_size), 64'(exp_size(wr_cnt)));
         cur_i = wr_cnt;
         wbeat = 0;
         wr_cnt++;
      end
      if (rd_val && rd_rdy) begin
         chk("rd_addr", 64'(rd_addr), 64'(rd_cnt * 256));
         chk("rd_size", 64'(rd_size), 64'(exp_size(rd_cnt)));
         q_txn.push_back(rd_cnt);
         q_size.push_back(exp_size(rd_cnt));
         rd_cnt++;
      end
      p_wv = wr_val; p_wr = wr_rdy; p_wa = wr_addr; p_ws = wr_size;
      p_dv = d_val;  p_dr = d_rdy;  p_dd = d_data;  p_dl = d_last; p_dp = d_pad;
      p_rv = rd_val; p_rr = rd_rdy; p_ra = rd_addr; p_rs = rd_size;
   endtask

   task automatic begin_run(input bit r, input int f, input bit h);
      rnd = r; flt = f; hold_rd = h;
      wr_cnt = 0; rd_cnt = 0; ret_j = 0; wbeat = 0; cur_i = 0;
      q_txn.delete(); q_size.delete(); mem.delete();
      p_wv = 0; p_dv = 0; p_rv = 0;
      @(negedge clk);
      wr_rdy = 0; d_rdy = 0; rd_rdy = 0; r_val = 0; start = 1;
      @(negedge clk);
      start = 0;
      chk("start_wr_val_next_cycle", 64'(wr_val), 64'(1));
      chk("start_clears_done", 64'(done), 64'(0));
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         step();
         n++;
      end
      chk("done_within_budget", 64'(done), 64'(1));
   endtask

   initial begin
      int n;
      rst = 1; start = 0; wr_rdy = 0; d_rdy = 0; rd_rdy = 0;
      r_val = 0; r_data = '0; r_last = 0; r_pad = '0;
      repeat (3) @(negedge clk);
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_pass", 64'(pass), 64'(0));
      chk("rst_fail_req", 64'(fail_req_idx), 64'(0));
      chk("rst_fail_flit", 64'(fail_flit_idx), 64'(0));
      chk("rst_vals", 64'({wr_val, d_val, rd_val, r_rdy}), 64'(0));
      rst = 0;

      // Clean run with random back-pressure; pad bytes of returns are corrupted.
      begin_run(1, 0, 0);
      wait_done(4000);
      chk("runA_pass", 64'(pass), 64'(1));
      chk("runA_writes", 64'(wr_cnt), 64'(4));
      chk("runA_reads", 64'(rd_cnt), 64'(4));
      repeat (5) step();
      chk("runA_done_sticky", 64'(done), 64'(1));
      chk("runA_pass_sticky", 64'(pass), 64'(1));
      chk("runA_idle_vals", 64'({wr_val, d_val, rd_val, r_rdy}), 64'(0));

      // Byte 5 of flit 1 of transaction 2 flipped on return.
      begin_run(1, 1, 0);
      wait_done(4000);
      chk("flip_pass", 64'(pass), 64'(0));
      chk("flip_fail_req", 64'(fail_req_idx), 64'(2));
      chk("flip_fail_flit", 64'(fail_flit_idx), 64'(1));
      repeat (10) step();
      chk("flip_no_more_writes", 64'(wr_cnt), 64'(3));
      chk("flip_no_more_reads", 64'(rd_cnt), 64'(3));
      chk("flip_done_sticky", 64'(done), 64'(1));

      // Early last on flit 0 of the 2-flit read of transaction 0.
      begin_run(1, 2, 0);
      wait_done(4000);
      chk("early_last_pass", 64'(pass), 64'(0));
      chk("early_last_fail_req", 64'(fail_req_idx), 64'(0));
      chk("early_last_fail_flit", 64'(fail_flit_idx), 64'(0));
      chk("early_last_writes", 64'(wr_cnt), 64'(1));

      // Reset while streaming write data.
      begin_run(0, 0, 0);
      n = 0;
      while (!d_val && n < 20) begin
         step();
         n++;
      end
      chk("reached_wr_data", 64'(d_val), 64'(1));
      rst = 1;
      @(negedge clk);
      chk("midrst_vals", 64'({wr_val, d_val, rd_val, r_rdy}), 64'(0));
      chk("midrst_done", 64'(done), 64'(0));
      chk("midrst_pass", 64'(pass), 64'(0));
      rst = 0;

      // Re-run after reset restarts from transaction 0.
      begin_run(1, 0, 0);
      wait_done(4000);
      chk("rerun_pass", 64'(pass), 64'(1));
      chk("rerun_writes", 64'(wr_cnt), 64'(4));

`ifdef TESTER_TRACE_DRIVER_TIMEOUT_EN
      begin_run(1, 0, 1);
      wait_done(4000);
      chk("timeout_pass", 64'(pass), 64'(0));
      chk("timeout_fail_req", 64'(fail_req_idx), 64'(0));
      chk("timeout_fail_flit", 64'(fail_flit_idx), 64'(16'hFFFF));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
